// File: rtl/bram_2psync_arbiter_if.sv
// Requester-side bus of the port-A arbiter: per-requester request/lock/write fields
// in, one-hot grant and read-valid plus the shared read data out.
interface bram_2psync_arbiter_if #(
  parameter int DATA = 8,
  parameter int ADDR = 7,
  parameter int NREQ = 3
);
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      lock;
  logic [NREQ-1:0]      we;
  logic [NREQ*ADDR-1:0] addr;
  logic [NREQ*DATA-1:0] wdata;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      rvalid;
  logic [DATA-1:0]      rdata;

  modport master (
    output req, lock, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, lock, we, addr, wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/bram_2psync_arbiter.sv
// Round-robin arbiter sharing port A of a bram_2psync among NREQ requesters, with a
// bounded lock (burst) feature and rvalid tagging for the RAM's 1-cycle read latency.
module bram_2psync_arbiter #(
  parameter int DATA     = 8,
  parameter int ADDR     = 7,
  parameter int NREQ     = 3,
  parameter int MAX_LOCK = 4
) (
  input  logic                 clk,
  input  logic                 nreset,
  bram_2psync_arbiter_if.slave bus,
  output logic                 m_we,
  output logic [ADDR-1:0]      m_addr,
  output logic [DATA-1:0]      m_write,
  input  logic [DATA-1:0]      m_read
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [IW-1:0] LAST = IW'(NREQ - 1);

  logic [IW-1:0]   ptr;
  logic [IW-1:0]   owner;
  logic            owner_vld;
  logic [CW-1:0]   lock_cnt;
  logic [NREQ-1:0] rvalid_q;

  logic            gnt_any;
  logic [IW-1:0]   gnt_idx;
  logic            lock_hold;
  logic [CW-1:0]   cnt_next;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == LAST) ? '0 : i + 1'b1;
  endfunction

  always_comb begin : select
    logic [IW-1:0] idx;
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    gnt_any   = 1'b0;
    gnt_idx   = '0;
    idx       = ptr;
    lock_hold = owner_vld && bus.req[owner] && (lock_cnt < CW'(MAX_LOCK));
    if (lock_hold) begin
      gnt_any = 1'b1;
      gnt_idx = owner;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (!gnt_any && bus.req[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = idx;
        end
        idx = next_idx(idx);
      end
    end
    if (!nreset) gnt_any = 1'b0;
  end

  // A grant to the current owner continues the burst; any other grant starts one.
  assign cnt_next = lock_hold ? lock_cnt + 1'b1 : CW'(1);

  assign bus.gnt    = gnt_any ? (NREQ'(1) << gnt_idx) : '0;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = m_read;

  // With no grant gnt_idx is 0, so the RAM sees requester 0's fields with m_we low.
  assign m_we    = gnt_any & bus.we[gnt_idx];
  assign m_addr  = bus.addr[gnt_idx*ADDR +: ADDR];
  assign m_write = bus.wdata[gnt_idx*DATA +: DATA];

  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments; a later assignment in this block
    // deliberately overrides an earlier one within the same edge.
    if (!nreset) begin
      ptr       <= '0;
      owner     <= '0;
      owner_vld <= 1'b0;
      lock_cnt  <= '0;
      rvalid_q  <= '0;
    end else begin
      rvalid_q <= (gnt_any && !bus.we[gnt_idx]) ? bus.gnt : '0;

      // Owner dropped its request: the burst ends and the pointer moves past it.
      if (owner_vld && !bus.req[owner]) begin
        owner_vld <= 1'b0;
        lock_cnt  <= '0;
        ptr       <= next_idx(owner);
      end

      if (gnt_any) begin
        if (bus.lock[gnt_idx] && (cnt_next < CW'(MAX_LOCK))) begin
          owner_vld <= 1'b1;
          owner     <= gnt_idx;
          lock_cnt  <= cnt_next;
        end else begin
          owner_vld <= 1'b0;
          lock_cnt  <= '0;
          ptr       <= next_idx(gnt_idx);
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_2psync_arbiter.sv
// Self-checking bench for bram_2psync_arbiter: vector table, hand-written corner
// sequences, then random traffic against a burst/round-robin reference model.
module tb_bram_2psync_arbiter;

  localparam int N  = 3;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int ML = 4;

  logic          clk    = 1'b0;
  logic          nreset = 1'b0;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_write;
  logic [DW-1:0] m_read;
  logic [DW-1:0] ram [2**AW];

  int total = 0;
  int bad   = 0;

  bram_2psync_arbiter_if #(.DATA(DW), .ADDR(AW), .NREQ(N)) bus ();

  bram_2psync_arbiter #(.DATA(DW), .ADDR(AW), .NREQ(N), .MAX_LOCK(ML)) dut (
    .clk     (clk),
    .nreset  (nreset),
    .bus     (bus),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_write (m_write),
    .m_read  (m_read)
  );

  always #5 clk = ~clk;

  // Port A of the RAM: registered read, one cycle latency.
  always @(posedge clk) begin
    if (m_we) ram[m_addr] <= m_write;
    m_read <= ram[m_addr];
  end

  typedef struct {
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] lock;
    logic [N-1:0] we;
    logic [N-1:0] gnt;
    logic [N-1:0] rvalid;
    logic         mwe;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                              input logic [N-1:0] w, input logic [N-1:0] g,
                              input logic [N-1:0] rv, input logic mw);
    vec_t v;
    v.rst = r; v.req = rq; v.lock = lk; v.we = w; v.gnt = g; v.rvalid = rv; v.mwe = mw;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic [N-1:0] rq, input logic [N-1:0] lk,
                       input logic [N-1:0] w);
    nreset   = rst;
    bus.req  = rq;
    bus.lock = lk;
    bus.we   = w;
  endtask

  task automatic set_fields(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.addr[i*AW +: AW]  = a;
    bus.wdata[i*DW +: DW] = d;
  endtask

  // Reference model: burst owner and its grant count, plus the rotating start point.
  int            m_ptr;
  int            m_owner;
  int            m_run;
  logic [N-1:0]  m_rv_exp;
  logic [DW-1:0] m_rd_exp;
  bit            m_rd_known;
  logic [DW-1:0] m_mem [2**AW];
  bit            m_known [2**AW];

  logic [N-1:0]  r_req, r_lock, r_we, pend, exp_g;
  logic [AW-1:0] r_addr [N];
  logic [DW-1:0] r_wd [N];
  logic          rst_now;
  int            g;

  function automatic int model_pick();
    if (m_owner >= 0 && r_req[m_owner] && m_run < ML) return m_owner;
    for (int k = 0; k < N; k++) begin
      if (r_req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = -1; m_run = 0; m_rv_exp = '0; m_rd_known = 0;
  endtask

  task automatic model_step(input int gi);
    m_rv_exp   = '0;
    m_rd_known = 0;
    if (m_owner >= 0 && !r_req[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_run   = 0;
    end
    if (gi >= 0) begin
      m_run = (gi == m_owner) ? m_run + 1 : 1;
      if (r_lock[gi] && m_run < ML) begin
        m_owner = gi;
      end else begin
        m_owner = -1;
        m_run   = 0;
        m_ptr   = (gi + 1) % N;
      end
      if (r_we[gi]) begin
        m_mem[r_addr[gi]]   = r_wd[gi];
        m_known[r_addr[gi]] = 1;
      end else begin
        m_rv_exp          = N'(1) << gi;
        m_rd_exp          = m_mem[r_addr[gi]];
        m_rd_known        = m_known[r_addr[gi]];
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, '0, '0, '0);
    bus.addr  = '0;
    bus.wdata = '0;
    repeat (2) @(posedge clk);

    // Reset, round-robin with back-to-back reads, lock limit, lock drop, owner req drop.
    tbl.push_back(mk(0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 0));
    tbl.push_back(mk(0, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 0));
    tbl.push_back(mk(1, 3'b111, 3'b000, 3'b000, 3'b001, 3'b000, 0));
    tbl.push_back(mk(1, 3'b111, 3'b000, 3'b000, 3'b010, 3'b001, 0));
    tbl.push_back(mk(1, 3'b111, 3'b000, 3'b000, 3'b100, 3'b010, 0));
    tbl.push_back(mk(1, 3'b111, 3'b000, 3'b000, 3'b001, 3'b100, 0));
    tbl.push_back(mk(1, 3'b111, 3'b000, 3'b000, 3'b010, 3'b001, 0));
    tbl.push_back(mk(1, 3'b111, 3'b000, 3'b000, 3'b100, 3'b010, 0));
    tbl.push_back(mk(1, 3'b011, 3'b001, 3'b011, 3'b001, 3'b100, 1));
    tbl.push_back(mk(1, 3'b011, 3'b001, 3'b011, 3'b001, 3'b000, 1));
    tbl.push_back(mk(1, 3'b011, 3'b001, 3'b011, 3'b001, 3'b000, 1));
    tbl.push_back(mk(1, 3'b011, 3'b001, 3'b011, 3'b001, 3'b000, 1));
    tbl.push_back(mk(1, 3'b011, 3'b001, 3'b011, 3'b010, 3'b000, 1));
    tbl.push_back(mk(1, 3'b011, 3'b001, 3'b011, 3'b001, 3'b000, 1));
    tbl.push_back(mk(1, 3'b011, 3'b001, 3'b011, 3'b001, 3'b000, 1));
    tbl.push_back(mk(1, 3'b011, 3'b001, 3'b011, 3'b001, 3'b000, 1));
    tbl.push_back(mk(1, 3'b011, 3'b001, 3'b011, 3'b001, 3'b000, 1));
    tbl.push_back(mk(1, 3'b011, 3'b001, 3'b011, 3'b010, 3'b000, 1));
    tbl.push_back(mk(1, 3'b011, 3'b001, 3'b000, 3'b001, 3'b000, 0));
    tbl.push_back(mk(1, 3'b011, 3'b000, 3'b000, 3'b001, 3'b001, 0));
    tbl.push_back(mk(1, 3'b011, 3'b000, 3'b000, 3'b010, 3'b001, 0));
    tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 0));
    tbl.push_back(mk(1, 3'b001, 3'b001, 3'b000, 3'b001, 3'b000, 0));
    tbl.push_back(mk(1, 3'b010, 3'b000, 3'b000, 3'b010, 3'b001, 0));
    tbl.push_back(mk(1, 3'b101, 3'b000, 3'b000, 3'b100, 3'b010, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].req, tbl[i].lock, tbl[i].we);
      #1;
      check($sformatf("vec%0d gnt", i), 32'(bus.gnt), 32'(tbl[i].gnt));
      check($sformatf("vec%0d rvalid", i), 32'(bus.rvalid), 32'(tbl[i].rvalid));
      check($sformatf("vec%0d m_we", i), 32'(m_we), 32'(tbl[i].mwe));
    end

    // Read latency: requester 1 writes 0x5A to 0x12, requester 2 reads it back.
    @(negedge clk);
    drive(1'b1, 3'b010, 3'b000, 3'b010);
    set_fields(1, 7'h12, 8'h5A);
    #1;
    check("lat wr gnt", 32'(bus.gnt), 32'(3'b010));
    check("lat wr m_we", 32'(m_we), 32'(1'b1));
    check("lat wr m_addr", 32'(m_addr), 32'(7'h12));
    check("lat wr m_write", 32'(m_write), 32'(8'h5A));
    @(negedge clk);
    drive(1'b1, 3'b100, 3'b000, 3'b000);
    set_fields(2, 7'h12, 8'h00);
    #1;
    check("lat rd gnt", 32'(bus.gnt), 32'(3'b100));
    check("lat rd rvalid", 32'(bus.rvalid), 32'(3'b000));
    check("lat rd m_we", 32'(m_we), 32'(1'b0));
    check("lat rd m_addr", 32'(m_addr), 32'(7'h12));
    @(negedge clk);
    drive(1'b1, 3'b000, 3'b000, 3'b000);
    #1;
    check("lat rvalid", 32'(bus.rvalid), 32'(3'b100));
    check("lat rdata", 32'(bus.rdata), 32'(8'h5A));
    @(negedge clk);
    #1;
    check("lat rvalid after", 32'(bus.rvalid), 32'(3'b000));

    // Reset during a locked read by requester 1.
    @(negedge clk);
    drive(1'b1, 3'b010, 3'b010, 3'b000);
    #1;
    check("rst lock gnt", 32'(bus.gnt), 32'(3'b010));
    @(negedge clk);
    drive(1'b0, 3'b011, 3'b010, 3'b000);
    #1;
    check("rst low gnt", 32'(bus.gnt), 32'(3'b000));
    check("rst low m_we", 32'(m_we), 32'(1'b0));
    check("rst low rvalid held", 32'(bus.rvalid), 32'(3'b010));
    @(negedge clk);
    drive(1'b1, 3'b011, 3'b000, 3'b000);
    #1;
    check("rst after gnt", 32'(bus.gnt), 32'(3'b001));
    check("rst after rvalid", 32'(bus.rvalid), 32'(3'b000));

    // Random traffic against the reference model.
    @(negedge clk);
    drive(1'b0, '0, '0, '0);
    model_reset();
    pend = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      rst_now = ($urandom_range(0, 79) != 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i]) begin
          r_req[i]  = ($urandom_range(0, 3) != 0);
          r_lock[i] = 1'($urandom_range(0, 1));
          r_we[i]   = 1'($urandom_range(0, 1));
          r_addr[i] = AW'($urandom_range(0, 15));
          r_wd[i]   = DW'($urandom);
        end
      end
      pend = r_req;
      drive(rst_now, r_req, r_lock, r_we);
      for (int i = 0; i < N; i++) set_fields(i, r_addr[i], r_wd[i]);
      #1;
      g     = rst_now ? model_pick() : -1;
      exp_g = (g >= 0) ? (N'(1) << g) : '0;
      check("rnd gnt", 32'(bus.gnt), 32'(exp_g));
      check("rnd m_we", 32'(m_we), 32'((g >= 0) ? r_we[g] : 1'b0));
      check("rnd rvalid", 32'(bus.rvalid), 32'(m_rv_exp));
      if (m_rv_exp != '0 && m_rd_known) check("rnd rdata", 32'(bus.rdata), 32'(m_rd_exp));
      if (g >= 0) check("rnd m_addr", 32'(m_addr), 32'(r_addr[g]));
      if (g >= 0 && r_we[g]) check("rnd m_write", 32'(m_write), 32'(r_wd[g]));
      if (!rst_now) begin
        model_reset();
      end else begin
        model_step(g);
        if (g >= 0) pend[g] = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
